// File: rtl/defuser_ctrl_if.sv
// Classic Wishbone master/slave bundle shared by the settings and board buses of defuser_ctrl.
// Signal names follow the master's point of view (_o driven by master, _i driven by slave).
interface defuser_ctrl_if #(
  parameter int ADR_W = 4,
  parameter int DAT_W = 16
) ();
  logic             cyc_o;
  logic             stb_o;
  logic             we_o;
  logic [ADR_W-1:0] adr_o;
  logic [DAT_W-1:0] dat_o;
  logic [DAT_W-1:0] dat_i;
  logic             ack_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/defuser_ctrl.sv
// Minesweeper player-input engine: caches game settings, maps the cursor to board fields and
// turns clicks into board read-modify-write cycles. Right-click flagging is built with DEFUSER_FLAG_EN.
module defuser_ctrl #(
  parameter int         SETTINGS_REG_NUM = 9,
  parameter int         IND_W            = 3,
  parameter logic [2:0] PLAY_STATE       = 3'd2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             planting_complete,
  input  logic [2:0]       main_state,
  input  logic [11:0]      mouse_xpos,
  input  logic [11:0]      mouse_ypos,
  input  logic             left,
  input  logic             right,
  output logic [IND_W-1:0] mouse_board_ind_x,
  output logic [IND_W-1:0] mouse_board_ind_y,
  output logic             mouse_xpos_valid,
  output logic             mouse_ypos_valid,
  defuser_ctrl_if.master   gs,
  defuser_ctrl_if.master   gb
);

  localparam int ROW_COLUMN_NUMBER = 0;
  localparam int MINE_NUM          = 1;
  localparam int TIMER_SECONDS     = 2;
  localparam int FIELD_SIZE        = 3;
  localparam int BOARD_SIZE        = 4;
  localparam int BOARD_XPOS        = 5;
  localparam int BOARD_YPOS        = 6;
  localparam int FIELD_NUM         = 2 ** IND_W;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    READ_SETTINGS = 3'd1,
    READY         = 3'd2,
    BOARD_RD      = 3'd3,
    BOARD_WR      = 3'd4
  } state_t;

  // New field word: left click reveals, right click toggles the flag.
  function automatic logic [7:0] next_field(input logic [7:0] rd, input logic is_right);
    if (is_right) begin
      return rd ^ 8'h04;
    end else begin
      return rd | 8'h02;
    end
  endfunction

  state_t      state_r;
  logic [15:0] game_setup_cashe_r [SETTINGS_REG_NUM];
  logic        settings_valid_r;
  logic        left_d_r;
  logic        click_right_r;
  logic [7:0]  field_r;

  logic [11:0]      dx_s;
  logic [11:0]      dy_s;
  logic             x_in_s;
  logic             y_in_s;
  logic [IND_W-1:0] ind_x_s;
  logic [IND_W-1:0] ind_y_s;
  logic             left_rise_s;
  logic             click_ok_s;
  logic             wr_skip_s;
  logic             last_setting_s;

`ifdef DEFUSER_FLAG_EN
  logic right_d_r;
  logic right_rise_s;
`else
  logic unused_right_s;
  assign unused_right_s = right;
`endif

  // Cursor-to-field mapping; the index is a count of field boundaries passed, so no divider is needed.
  always_comb begin
    dx_s    = mouse_xpos - game_setup_cashe_r[BOARD_XPOS][11:0];
    dy_s    = mouse_ypos - game_setup_cashe_r[BOARD_YPOS][11:0];
    x_in_s  = settings_valid_r
              && ({4'd0, mouse_xpos} >= game_setup_cashe_r[BOARD_XPOS])
              && ({4'd0, dx_s} < game_setup_cashe_r[BOARD_SIZE]);
    y_in_s  = settings_valid_r
              && ({4'd0, mouse_ypos} >= game_setup_cashe_r[BOARD_YPOS])
              && ({4'd0, dy_s} < game_setup_cashe_r[BOARD_SIZE]);
    ind_x_s = '0;
    ind_y_s = '0;
    for (int i = 1; i < FIELD_NUM; i++) begin
      if (32'(dx_s) >= 32'(i) * 32'(game_setup_cashe_r[FIELD_SIZE])) begin
        ind_x_s = ind_x_s + IND_W'(1);
      end else begin
        ind_x_s = ind_x_s;
      end
      if (32'(dy_s) >= 32'(i) * 32'(game_setup_cashe_r[FIELD_SIZE])) begin
        ind_y_s = ind_y_s + IND_W'(1);
      end else begin
        ind_y_s = ind_y_s;
      end
    end
  end

  // Click qualification and the flagged-field write suppression.
  always_comb begin
    left_rise_s    = left & ~left_d_r;
    click_ok_s     = (main_state == PLAY_STATE) && mouse_xpos_valid && mouse_ypos_valid;
    last_setting_s = (gs.adr_o == 4'(SETTINGS_REG_NUM - 1));
`ifdef DEFUSER_FLAG_EN
    right_rise_s   = right & ~right_d_r;
    wr_skip_s      = ~click_right_r & field_r[2];
`else
    wr_skip_s      = 1'b0;
`endif
  end

  // Registered index/valid outputs and button history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mouse_board_ind_x <= '0;
      mouse_board_ind_y <= '0;
      mouse_xpos_valid  <= 1'b0;
      mouse_ypos_valid  <= 1'b0;
      left_d_r          <= 1'b0;
`ifdef DEFUSER_FLAG_EN
      right_d_r         <= 1'b0;
`endif
    end else begin
      mouse_board_ind_x <= ind_x_s;
      mouse_board_ind_y <= ind_y_s;
      mouse_xpos_valid  <= x_in_s;
      mouse_ypos_valid  <= y_in_s;
      left_d_r          <= left;
`ifdef DEFUSER_FLAG_EN
      right_d_r         <= right;
`endif
    end
  end

  // Control FSM: settings fetch, then click-driven board read-modify-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= IDLE;
      settings_valid_r <= 1'b0;
      click_right_r    <= 1'b0;
      field_r          <= 8'd0;
      gs.cyc_o         <= 1'b0;
      gs.stb_o         <= 1'b0;
      gs.we_o          <= 1'b0;
      gs.adr_o         <= 4'd0;
      gs.dat_o         <= 16'd0;
      gb.cyc_o         <= 1'b0;
      gb.stb_o         <= 1'b0;
      gb.we_o          <= 1'b0;
      gb.adr_o         <= 8'd0;
      gb.dat_o         <= 8'd0;
      for (int i = 0; i < SETTINGS_REG_NUM; i++) begin
        game_setup_cashe_r[i] <= 16'd0;
      end
    end else if ((state_r != IDLE) && !planting_complete) begin
      // Losing the planted board aborts any transfer; the cache is kept.
      state_r  <= IDLE;
      gs.cyc_o <= 1'b0;
      gs.stb_o <= 1'b0;
      gb.cyc_o <= 1'b0;
      gb.stb_o <= 1'b0;
      gb.we_o  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (planting_complete) begin
            state_r          <= READ_SETTINGS;
            settings_valid_r <= 1'b0;
            gs.adr_o         <= 4'd0;
            gs.cyc_o         <= 1'b1;
            gs.stb_o         <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        READ_SETTINGS: begin
          if (gs.cyc_o) begin
            if (gs.ack_i) begin
              if (gs.adr_o < 4'(SETTINGS_REG_NUM)) begin
                game_setup_cashe_r[gs.adr_o] <= gs.dat_i;
              end else begin
                game_setup_cashe_r[0] <= game_setup_cashe_r[0];
              end
              gs.cyc_o <= 1'b0;
              gs.stb_o <= 1'b0;
              if (last_setting_s) begin
                state_r          <= READY;
                settings_valid_r <= 1'b1;
              end else begin
                gs.adr_o <= gs.adr_o + 4'd1;
              end
            end else begin
              state_r <= READ_SETTINGS;
            end
          end else begin
            gs.cyc_o <= 1'b1;
            gs.stb_o <= 1'b1;
          end
        end
        READY: begin
          if (click_ok_s && left_rise_s) begin
            click_right_r <= 1'b0;
            gb.adr_o      <= {4'(mouse_board_ind_y), 4'(mouse_board_ind_x)};
            gb.cyc_o      <= 1'b1;
            gb.stb_o      <= 1'b1;
            gb.we_o       <= 1'b0;
            state_r       <= BOARD_RD;
`ifdef DEFUSER_FLAG_EN
          end else if (click_ok_s && right_rise_s) begin
            click_right_r <= 1'b1;
            gb.adr_o      <= {4'(mouse_board_ind_y), 4'(mouse_board_ind_x)};
            gb.cyc_o      <= 1'b1;
            gb.stb_o      <= 1'b1;
            gb.we_o       <= 1'b0;
            state_r       <= BOARD_RD;
`endif
          end else begin
            state_r <= READY;
          end
        end
        BOARD_RD: begin
          if (gb.ack_i) begin
            field_r  <= gb.dat_i;
            gb.cyc_o <= 1'b0;
            gb.stb_o <= 1'b0;
            state_r  <= BOARD_WR;
          end else begin
            state_r <= BOARD_RD;
          end
        end
        BOARD_WR: begin
          if (gb.cyc_o) begin
            if (gb.ack_i) begin
              gb.cyc_o <= 1'b0;
              gb.stb_o <= 1'b0;
              gb.we_o  <= 1'b0;
              state_r  <= READY;
            end else begin
              state_r <= BOARD_WR;
            end
          end else if (wr_skip_s) begin
            state_r <= READY;
          end else begin
            gb.dat_o <= next_field(field_r, click_right_r);
            gb.cyc_o <= 1'b1;
            gb.stb_o <= 1'b1;
            gb.we_o  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_defuser_ctrl.sv
// Directed self-checking bench for defuser_ctrl with single-cycle-ack settings and board slaves.
module tb_defuser_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        planting_complete;
  logic [2:0]  main_state;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        left;
  logic        right;
  logic [2:0]  mouse_board_ind_x;
  logic [2:0]  mouse_board_ind_y;
  logic        mouse_xpos_valid;
  logic        mouse_ypos_valid;

  defuser_ctrl_if #(.ADR_W(4), .DAT_W(16)) gs ();
  defuser_ctrl_if #(.ADR_W(8), .DAT_W(8))  gb ();

  defuser_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .planting_complete (planting_complete),
    .main_state        (main_state),
    .mouse_xpos        (mouse_xpos),
    .mouse_ypos        (mouse_ypos),
    .left              (left),
    .right             (right),
    .mouse_board_ind_x (mouse_board_ind_x),
    .mouse_board_ind_y (mouse_board_ind_y),
    .mouse_xpos_valid  (mouse_xpos_valid),
    .mouse_ypos_valid  (mouse_ypos_valid),
    .gs                (gs),
    .gb                (gb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] SETTINGS [9] = '{16'd8, 16'd10, 16'd240, 16'd32, 16'd256,
                                           16'd100, 16'd50, 16'd0, 16'd0};

  // Settings slave: one-cycle ack, logs every address it serves.
  int         gs_rd_cnt;
  int         gs_nogap_cnt;
  logic       gs_prev_ack;
  logic [3:0] gs_adr_log [32];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      gs.ack_i     <= 1'b0;
      gs.dat_i     <= 16'd0;
      gs_rd_cnt    <= 0;
      gs_nogap_cnt <= 0;
      gs_prev_ack  <= 1'b0;
    end else begin
      gs_prev_ack <= gs.ack_i;
      if (gs_prev_ack && gs.cyc_o) gs_nogap_cnt <= gs_nogap_cnt + 1;
      if (gs.cyc_o && gs.stb_o && !gs.ack_i) begin
        gs.ack_i <= 1'b1;
        gs.dat_i <= (gs.adr_o < 4'd9) ? SETTINGS[gs.adr_o] : 16'hDEAD;
        if (gs_rd_cnt < 32) gs_adr_log[gs_rd_cnt] <= gs.adr_o;
        gs_rd_cnt <= gs_rd_cnt + 1;
      end else begin
        gs.ack_i <= 1'b0;
      end
    end
  end

  // Board slave: returns gb_rd_val on reads and records writes.
  logic [7:0] gb_rd_val;
  int         gb_rd_cnt;
  int         gb_wr_cnt;
  logic [7:0] gb_last_rd_adr;
  logic [7:0] gb_last_wr_adr;
  logic [7:0] gb_last_wr_dat;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      gb.ack_i       <= 1'b0;
      gb.dat_i       <= 8'd0;
      gb_rd_cnt      <= 0;
      gb_wr_cnt      <= 0;
      gb_last_rd_adr <= 8'd0;
      gb_last_wr_adr <= 8'd0;
      gb_last_wr_dat <= 8'd0;
    end else if (gb.cyc_o && gb.stb_o && !gb.ack_i) begin
      gb.ack_i <= 1'b1;
      if (gb.we_o) begin
        gb_wr_cnt      <= gb_wr_cnt + 1;
        gb_last_wr_adr <= gb.adr_o;
        gb_last_wr_dat <= gb.dat_o;
      end else begin
        gb.dat_i       <= gb_rd_val;
        gb_rd_cnt      <= gb_rd_cnt + 1;
        gb_last_rd_adr <= gb.adr_o;
      end
    end else begin
      gb.ack_i <= 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mouse(input logic [11:0] x, input logic [11:0] y);
    mouse_xpos = x;
    mouse_ypos = y;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b0; planting_complete = 1'b0; main_state = 3'd0;
    mouse_xpos = 12'd102; mouse_ypos = 12'd52; left = 1'b0; right = 1'b0;
    gb_rd_val = 8'h00;
    tick(10);
    checks++;
    if ({gs.cyc_o, gs.stb_o, gs.we_o, gs.adr_o} !== 7'd0) begin
      errors++; $display("FAIL reset_gs: got %b required 0", {gs.cyc_o, gs.stb_o, gs.we_o, gs.adr_o});
    end
    checks++;
    if ({gb.cyc_o, gb.stb_o, gb.we_o, gb.adr_o, gb.dat_o} !== 19'd0) begin
      errors++; $display("FAIL reset_gb: got %h required 0", {gb.cyc_o, gb.stb_o, gb.we_o, gb.adr_o, gb.dat_o});
    end
    checks++;
    if ({mouse_board_ind_x, mouse_board_ind_y, mouse_xpos_valid, mouse_ypos_valid} !== 8'd0) begin
      errors++; $display("FAIL reset_map: got %b required 0",
                         {mouse_board_ind_x, mouse_board_ind_y, mouse_xpos_valid, mouse_ypos_valid});
    end
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_settings_read();
    bit done = 1'b0;
    planting_complete = 1'b1;
    tick(5);
    checks++;
    if ({mouse_xpos_valid, mouse_ypos_valid} !== 2'b00) begin
      errors++; $display("FAIL valid_during_read: got %b required 00", {mouse_xpos_valid, mouse_ypos_valid});
    end
    for (int c = 0; c < 150; c++) begin
      if (gs_rd_cnt == 9 && !gs.cyc_o) begin done = 1'b1; break; end
      tick(1);
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL settings_timeout: got %0d reads required 9", gs_rd_cnt);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (gs_adr_log[i] !== 4'(i)) begin
        errors++; $display("FAIL settings_order[%0d]: got %0d required %0d", i, gs_adr_log[i], i);
      end
    end
    checks++;
    if (gs_nogap_cnt !== 0) begin
      errors++; $display("FAIL settings_gap: got %0d back-to-back cycles required 0", gs_nogap_cnt);
    end
    checks++;
    if ({dut.game_setup_cashe_r[0], dut.game_setup_cashe_r[3], dut.game_setup_cashe_r[5],
         dut.game_setup_cashe_r[6]} !== {16'd8, 16'd32, 16'd100, 16'd50}) begin
      errors++; $display("FAIL cache: got %0d %0d %0d %0d required 8 32 100 50",
                         dut.game_setup_cashe_r[0], dut.game_setup_cashe_r[3],
                         dut.game_setup_cashe_r[5], dut.game_setup_cashe_r[6]);
    end
    tick(2);
    checks++;
    if ({mouse_xpos_valid, mouse_ypos_valid, mouse_board_ind_x, mouse_board_ind_y} !== 8'b11_000_000) begin
      errors++; $display("FAIL map_origin: got %b required 11000000",
                         {mouse_xpos_valid, mouse_ypos_valid, mouse_board_ind_x, mouse_board_ind_y});
    end
  endtask

  task automatic test_index_map();
    set_mouse(12'd137, 12'd52);
    checks++;
    if ({mouse_xpos_valid, mouse_board_ind_x} !== 4'b1_001) begin
      errors++; $display("FAIL map_x137: got %b required 1001", {mouse_xpos_valid, mouse_board_ind_x});
    end
    set_mouse(12'd355, 12'd52);
    checks++;
    if ({mouse_xpos_valid, mouse_board_ind_x} !== 4'b1_111) begin
      errors++; $display("FAIL map_x355: got %b required 1111", {mouse_xpos_valid, mouse_board_ind_x});
    end
    set_mouse(12'd356, 12'd52);
    checks++;
    if (mouse_xpos_valid !== 1'b0) begin
      errors++; $display("FAIL map_x356: got %b required 0", mouse_xpos_valid);
    end
    set_mouse(12'd99, 12'd52);
    checks++;
    if (mouse_xpos_valid !== 1'b0) begin
      errors++; $display("FAIL map_x99: got %b required 0", mouse_xpos_valid);
    end
    set_mouse(12'd102, 12'd305);
    checks++;
    if ({mouse_ypos_valid, mouse_board_ind_y} !== 4'b1_111) begin
      errors++; $display("FAIL map_y305: got %b required 1111", {mouse_ypos_valid, mouse_board_ind_y});
    end
    set_mouse(12'd102, 12'd306);
    checks++;
    if (mouse_ypos_valid !== 1'b0) begin
      errors++; $display("FAIL map_y306: got %b required 0", mouse_ypos_valid);
    end
    set_mouse(12'd137, 12'd52);
  endtask

  task automatic click(input logic l, input logic r);
    left = l; right = r;
    tick(20);
    left = 1'b0; right = 1'b0;
    tick(2);
  endtask

  task automatic test_left_click();
    int rd0 = gb_rd_cnt;
    int wr0 = gb_wr_cnt;
    main_state = 3'd2;
    gb_rd_val  = 8'h00;
    tick(2);
    click(1'b1, 1'b0);
    checks++;
    if ((gb_rd_cnt - rd0) !== 1 || gb_last_rd_adr !== 8'h01) begin
      errors++; $display("FAIL left_read: got %0d reads at %h required 1 at 01", gb_rd_cnt - rd0, gb_last_rd_adr);
    end
    checks++;
    if ((gb_wr_cnt - wr0) !== 1 || gb_last_wr_adr !== 8'h01 || gb_last_wr_dat !== 8'h02) begin
      errors++; $display("FAIL left_write: got %0d writes %h<=%h required 1 01<=02",
                         gb_wr_cnt - wr0, gb_last_wr_adr, gb_last_wr_dat);
    end
  endtask

  task automatic test_right_click();
    int rd0 = gb_rd_cnt;
    int wr0 = gb_wr_cnt;
    gb_rd_val = 8'h00;
    click(1'b0, 1'b1);
`ifdef DEFUSER_FLAG_EN
    checks++;
    if ((gb_wr_cnt - wr0) !== 1 || gb_last_wr_adr !== 8'h01 || gb_last_wr_dat !== 8'h04) begin
      errors++; $display("FAIL right_flag: got %0d writes %h<=%h required 1 01<=04",
                         gb_wr_cnt - wr0, gb_last_wr_adr, gb_last_wr_dat);
    end
    rd0 = gb_rd_cnt; wr0 = gb_wr_cnt;
    gb_rd_val = 8'h04;
    click(1'b1, 1'b0);
    checks++;
    if ((gb_rd_cnt - rd0) !== 1 || (gb_wr_cnt - wr0) !== 0) begin
      errors++; $display("FAIL left_on_flag: got %0d reads %0d writes required 1 0", gb_rd_cnt - rd0, gb_wr_cnt - wr0);
    end
    wr0 = gb_wr_cnt;
    gb_rd_val = 8'h00;
    click(1'b1, 1'b1);
    checks++;
    if ((gb_wr_cnt - wr0) !== 1 || gb_last_wr_dat !== 8'h02) begin
      errors++; $display("FAIL both_left_wins: got %0d writes data %h required 1 02", gb_wr_cnt - wr0, gb_last_wr_dat);
    end
`else
    checks++;
    if ((gb_rd_cnt - rd0) !== 0 || (gb_wr_cnt - wr0) !== 0) begin
      errors++; $display("FAIL right_ignored: got %0d reads %0d writes required 0 0", gb_rd_cnt - rd0, gb_wr_cnt - wr0);
    end
    wr0 = gb_wr_cnt;
    gb_rd_val = 8'h04;
    click(1'b1, 1'b0);
    checks++;
    if ((gb_wr_cnt - wr0) !== 1 || gb_last_wr_dat !== 8'h06) begin
      errors++; $display("FAIL left_no_flag_check: got %0d writes data %h required 1 06", gb_wr_cnt - wr0, gb_last_wr_dat);
    end
`endif
  endtask

  task automatic test_click_ignored();
    int rd0 = gb_rd_cnt;
    set_mouse(12'd99, 12'd52);
    tick(1);
    click(1'b1, 1'b0);
    checks++;
    if ((gb_rd_cnt - rd0) !== 0) begin
      errors++; $display("FAIL click_outside: got %0d reads required 0", gb_rd_cnt - rd0);
    end
    set_mouse(12'd137, 12'd52);
    main_state = 3'd0;
    tick(1);
    click(1'b1, 1'b0);
    checks++;
    if ((gb_rd_cnt - rd0) !== 0) begin
      errors++; $display("FAIL click_not_play: got %0d reads required 0", gb_rd_cnt - rd0);
    end
    main_state = 3'd2;
  endtask

  task automatic test_abort_restart();
    bit hit = 1'b0;
    int snap;
    rst = 1'b0; planting_complete = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    planting_complete = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (gs_rd_cnt >= 3 && gs.cyc_o) begin hit = 1'b1; break; end
      tick(1);
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL abort_setup_timeout: got %0d reads required 3", gs_rd_cnt);
    end
    planting_complete = 1'b0;
    tick(1);
    checks++;
    if ({gs.cyc_o, gs.stb_o} !== 2'b00) begin
      errors++; $display("FAIL abort_drop: got cyc/stb %b required 00", {gs.cyc_o, gs.stb_o});
    end
    tick(5);
    snap = gs_rd_cnt;
    checks++;
    if (gs.cyc_o !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got cyc %b required 0", gs.cyc_o);
    end
    planting_complete = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (gs_rd_cnt == snap + 9 && !gs.cyc_o) begin hit = 1'b1; break; end
      tick(1);
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL restart_timeout: got %0d reads required %0d", gs_rd_cnt, snap + 9);
    end
    checks++;
    if (gs_adr_log[snap] !== 4'd0 || gs_adr_log[snap + 8] !== 4'd8) begin
      errors++; $display("FAIL restart_order: got first %0d last %0d required 0 8",
                         gs_adr_log[snap], gs_adr_log[snap + 8]);
    end
  endtask

  initial begin
    test_reset();
    test_settings_read();
    test_index_map();
    test_left_click();
    test_right_click();
    test_click_ignored();
    test_abort_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/defuser_ctrl.md
Name: defuser_ctrl

Overview:
- Player-input engine of the Minesweeper core.
- After mine planting completes, it reads the game-settings register bank over a Wishbone master port and caches it locally.
- It then maps the mouse position to board field indices every cycle.
- It turns left/right clicks into read-modify-write accesses on the game-board memory over a second Wishbone master port.
- It sits between the mouse/PS2 front end, main_fsm (settings slave) and the board memory.

Parameters:
- SETTINGS_REG_NUM, 9, number of 16-bit settings registers read into the cache (addresses 0..8).
- IND_W, 3, width of the board index outputs (max 8x8 addressable fields).
- PLAY_STATE, 3'd2, main_state encoding in which clicks are processed.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- planting_complete  in  1  level; board memory holds planted mines.
- main_state  in  3  main_fsm state.
- mouse_xpos  in  12  pixel X.
- mouse_ypos  in  12  pixel Y.
- left  in  1  left button level.
- right  in  1  right button level.
- mouse_board_ind_x  out  IND_W  field column under cursor.
- mouse_board_ind_y  out  IND_W  field row under cursor.
- mouse_xpos_valid  out  1  cursor X inside board.
- mouse_ypos_valid  out  1  cursor Y inside board.
- gs_cyc_o, gs_stb_o, gs_we_o  out  1 each  settings bus; we tied 0.
- gs_adr_o  out  4  settings register address.
- gs_dat_i  in  16  settings read data.
- gs_ack_i  in  1  settings ack.
- gb_cyc_o, gb_stb_o, gb_we_o  out  1 each  board bus.
- gb_adr_o  out  8  board address {y[3:0],x[3:0]}.
- gb_dat_o  out  8  board write data.
- gb_dat_i  in  8  board read data.
- gb_ack_i  in  1  board ack.

Behaviour:
- Reset (rst=0, async):
  - all outputs 0;
  - cache registers game_setup_cashe[0..8] cleared;
  - FSM to IDLE.
- Cache register names (game_pkg): ROW_COLUMN_NUMBER, MINE_NUM, TIMER_SECONDS, FIELD_SIZE, BOARD_SIZE, BOARD_XPOS, BOARD_YPOS.
- FSM states:
  - IDLE: go to READ_SETTINGS when planting_complete=1.
  - READ_SETTINGS:
    - Single outstanding classic-cycle read per address 0..SETTINGS_REG_NUM-1 in order.
    - cyc/stb held with adr until gs_ack_i; gs_dat_i captured into cache[adr] on the ack cycle.
    - cyc/stb drop for one cycle between reads.
    - After the last ack go to READY.
    - Full read completes within 150 cycles for an ack latency of at most 10 cycles.
  - READY:
    - Needs main_state==PLAY_STATE and a rising edge of left (or of right, see feature) with both valid flags 1.
    - On such an edge, latch ind_x/ind_y and go to BOARD_RD.
    - Edges while valid=0 are ignored.
  - BOARD_RD: read the field at {ind_y,ind_x}; on gb_ack_i, store the word and go to BOARD_WR.
  - BOARD_WR:
    - Left click: data = rd | 8'h02 (revealed), unless flagged (bit2) — then skip the write.
    - Right click: data = rd ^ 8'h04.
    - Hold the write until ack, then return to READY.
    - Clicks arriving during BOARD_RD/BOARD_WR are dropped.
- Field word format: bit0 mine, bit1 revealed, bit2 flagged, [7:4] neighbour count. Only bits 1 and 2 are modified.
- planting_complete falling to 0 in any state:
  - abort at the next clock and return to IDLE;
  - cyc/stb drop;
  - cache retained until the next settings read.
- Index mapping (registered, 1-cycle latency from mouse inputs):
  - dx = mouse_xpos - BOARD_XPOS (12-bit unsigned).
  - mouse_xpos_valid = (mouse_xpos >= BOARD_XPOS) && (dx < BOARD_SIZE).
  - mouse_board_ind_x = number of i in 1..2^IND_W-1 with dx >= i*FIELD_SIZE; computed with constant-multiplier comparators, no divider.
  - Y identical, using BOARD_YPOS.
  - Index outputs are undefined-but-stable (computed as above) when valid=0.
- Valid outputs are 0 until the settings read completes.
- Button edge detection: one register per button; simultaneous left and right rising edges → left wins.

Optional Feature:
- Macro DEFUSER_FLAG_EN.
- Defined: right-click flag toggling enabled as described.
- Undefined: right input ignored entirely (no board access); left click never checks bit2.

Test Plan:
- Reset 10 cycles, planting_complete=1, slave acks in 1 cycle, settings {8,10,240,32,256,100,50,...} → within 150 cycles cache ROW_COLUMN=8, FIELD_SIZE=32, BOARD_XPOS=100, BOARD_YPOS=50, FSM READY.
- Mouse (102,52) → after 1 clock both valid=1, ind_x=0, ind_y=0.
- Mouse x to 137 (102+32+3) → after 1 clock ind_x=1; x=355 → ind_x=7; x=356 or x=99 → mouse_xpos_valid=0.
- main_state=PLAY_STATE, left edge at (137,52), board returns 8'h00 → one read then write addr 8'h01, data 8'h02.
- With DEFUSER_FLAG_EN: right edge at the same field, read 8'h00 → write 8'h04; a following left edge reads 8'h04 → no write cycle.
- Drop planting_complete mid-READ_SETTINGS → IDLE next clock, gs_cyc_o=0; reassert → the read restarts from address 0.
